// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART constants and helpers. Holds the baud
//                accumulator sizing math used by both the receive and
//                transmit tick generators, and the receiver state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Number of bits needed to represent v (0 -> 0, 1 -> 1, 217 -> 8).
  // Sizing is done on this bit count, not on floor(log2(v)).
  function automatic int log2(input longint v);
    int r;
    r = 0;
    while ((v >> r) != 0) r++;
    return r;
  endfunction

  // Accumulator width: enough bits for the clk/baud ratio plus 8 bits of
  // fractional resolution.
  function automatic int acc_width(input longint clk_hz, input longint baud);
    return log2(clk_hz / baud) + 8;
  endfunction

  // Accumulator increment for a tick rate of `rate` Hz. Operands are
  // pre-shifted (ShiftLimiter) so the intermediate product stays inside
  // 32 bits, and the division is rounded to nearest.
  function automatic longint acc_inc(input longint clk_hz, input longint rate,
                                     input int aw);
    int shl;
    shl = log2(rate >> (31 - aw));
    return ((rate << (aw - shl)) + (clk_hz >> (shl + 1))) / (clk_hz >> shl);
  endfunction

  // Receiver FSM state encoding.
  typedef logic [2:0] rx_state_t;
  localparam rx_state_t c_ST_IDLE  = 3'd0;
  localparam rx_state_t c_ST_START = 3'd1;
  localparam rx_state_t c_ST_DATA  = 3'd2;
  localparam rx_state_t c_ST_STOP  = 3'd3;
  localparam rx_state_t c_ST_BREAK = 3'd4;

endpackage
`default_nettype wire

// File: rtl/uart_rx_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_tick_gen
//  Description : Free-running fractional accumulator producing the
//                oversampled bit tick (Baud * Oversampling) for the receiver.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_tick_gen
  import uart_pkg::*;
#(
  parameter int ClkFrequency = 25000000,
  parameter int Baud         = 115200,
  parameter int Oversampling = 8
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int         c_ACC_W = acc_width(ClkFrequency, Baud);
  localparam int         c_W1    = c_ACC_W + 1;
  localparam longint     c_INC_L = acc_inc(ClkFrequency,
                                           longint'(Baud) * Oversampling,
                                           c_ACC_W);
  localparam logic [c_ACC_W:0] c_INC = c_W1'(c_INC_L);

  logic [c_ACC_W:0] r_acc;

  // Accumulate the increment; the carry out of the fractional part is the tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_acc <= '0;
    else        r_acc <= {1'b0, r_acc[c_ACC_W-1:0]} + c_INC;
  end

  assign tick = r_acc[c_ACC_W];

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : 8N1 asynchronous serial receiver, LSB first. Synchronizes
//                rxd, validates the start bit at mid-bit, shifts in 8 data
//                bits, checks the stop bit and strobes the byte out.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
  import uart_pkg::*;
#(
  parameter int ClkFrequency = 25000000,
  parameter int Baud         = 115200,
  parameter int Oversampling = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       framing_err,
  output logic       busy
);

  localparam int              c_CNT_W = $clog2(Oversampling) + 1;
  localparam logic [c_CNT_W-1:0] c_OS   = c_CNT_W'(Oversampling);
  localparam logic [c_CNT_W-1:0] c_HALF = c_CNT_W'(Oversampling / 2);
  localparam logic [c_CNT_W-1:0] c_ONE  = c_CNT_W'(1);

  // Oversampling must be a power of two and at least 4 so mid-bit lands
  // on a whole tick.
  if ((Oversampling < 4) || ((Oversampling & (Oversampling - 1)) != 0)) begin : g_bad_oversampling
    $error("uart_rx: Oversampling must be a power of 2 and >= 4");
  end

  logic               w_tick;
  logic               r_sync1;
  logic               r_sync2;
  logic               w_rxd_s;
  rx_state_t          r_state;
  logic [c_CNT_W-1:0] r_cnt;
  logic [2:0]         r_bitn;
  logic [7:0]         r_shreg;
  logic [7:0]         r_data;
  logic               r_valid;
  logic               r_ferr;

  uart_rx_tick_gen #(
    .ClkFrequency (ClkFrequency),
    .Baud         (Baud),
    .Oversampling (Oversampling)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (w_tick)
  );

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rxd;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rxd_s = r_sync2;

  // Frame FSM: advances only on ticks; strobes are cleared every clk so
  // they last exactly one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_ST_IDLE;
      r_cnt   <= '0;
      r_bitn  <= '0;
      r_shreg <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      if (w_tick) begin
        case (r_state)
          c_ST_IDLE: begin
            if (!w_rxd_s) begin
              r_state <= c_ST_START;
              r_cnt   <= c_ONE;
            end
          end
          c_ST_START: begin
            if (r_cnt == c_HALF) begin
              if (!w_rxd_s) begin
                r_state <= c_ST_DATA;
                r_cnt   <= c_ONE;
                r_bitn  <= 3'd0;
              end else begin
                // Line went back high before mid-bit: a glitch, not a start.
                r_state <= c_ST_IDLE;
              end
            end else begin
              r_cnt <= r_cnt + c_ONE;
            end
          end
          c_ST_DATA: begin
            if (r_cnt == c_OS) begin
              r_shreg <= {w_rxd_s, r_shreg[7:1]};
              r_cnt   <= c_ONE;
              if (r_bitn == 3'd7) r_state <= c_ST_STOP;
              else                r_bitn  <= r_bitn + 3'd1;
            end else begin
              r_cnt <= r_cnt + c_ONE;
            end
          end
          c_ST_STOP: begin
            if (r_cnt == c_OS) begin
              if (w_rxd_s) begin
                r_data  <= r_shreg;
                r_valid <= 1'b1;
                r_state <= c_ST_IDLE;
              end else begin
                r_ferr  <= 1'b1;
                r_state <= c_ST_BREAK;
              end
            end else begin
              r_cnt <= r_cnt + c_ONE;
            end
          end
          c_ST_BREAK: begin
            // Wait for the line to return high so a held-low line is not
            // decoded as a stream of 0x00 bytes.
            if (w_rxd_s) r_state <= c_ST_IDLE;
          end
          default: r_state <= c_ST_IDLE;
        endcase
      end
    end
  end

  assign data        = r_data;
  assign data_valid  = r_valid;
  assign framing_err = r_ferr;
  assign busy        = (r_state != c_ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx
//  Description : Scoreboard bench for uart_rx. Stimulus pushes the expected
//                outcome of each frame; a monitor pops on every strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

  localparam int c_BIT = 217;  // nominal clk per bit at 25 MHz / 115200

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rxd = 1'b1;
  logic [7:0] data;
  logic       data_valid;
  logic       framing_err;
  logic       busy;

  typedef struct packed {
    logic       ferr;
    logic [7:0] b;
  } exp_t;

  exp_t       q[$];
  exp_t       mon_e;
  int         n_vec = 0;
  int         n_bad = 0;
  logic [7:0] last_good = 8'h00;

  always #20 clk = ~clk;

  uart_rx #(
    .ClkFrequency (25000000),
    .Baud         (115200),
    .Oversampling (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rxd         (rxd),
    .data        (data),
    .data_valid  (data_valid),
    .framing_err (framing_err),
    .busy        (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && (data_valid || framing_err)) begin
      if (q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_strobe: dv=%0b ferr=%0b data=0x%02h, expected no strobe",
                 data_valid, framing_err, data);
      end else begin
        mon_e = q.pop_front();
        chk("strobe_ferr", {31'd0, framing_err}, {31'd0, mon_e.ferr});
        chk("strobe_dv", {31'd0, data_valid}, {31'd0, ~mon_e.ferr});
        if (mon_e.ferr) begin
          chk("data_hold_on_ferr", {24'd0, data}, {24'd0, last_good});
        end else begin
          chk("rx_byte", {24'd0, data}, {24'd0, mon_e.b});
          last_good = mon_e.b;
        end
      end
    end
  end

  task automatic drive_bits(input logic v, input int n);
    rxd = v;
    repeat (n) @(negedge clk);
  endtask

  // One 8N1 frame; the expected outcome follows from the stop bit alone.
  task automatic send_frame(input logic [7:0] b, input logic stopb, input int bitclk);
    exp_t e;
    e.ferr = ~stopb;
    e.b    = b;
    q.push_back(e);
    drive_bits(1'b0, bitclk);
    chk("busy_in_frame", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 8; i++) drive_bits(b[i], bitclk);
    drive_bits(stopb, bitclk);
  endtask

  task automatic wait_drain(input int max_cyc);
    int k;
    k = 0;
    while (q.size() != 0 && k < max_cyc) begin
      @(negedge clk);
      k++;
    end
    chk("queue_drained", q.size(), 32'd0);
  endtask

  // Watchdog against a hung run.
  initial begin
    #(150000 * 40);
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int bitclk;
    int gap;
    logic [7:0] rb;
    logic       rs;

    // Reset state
    repeat (5) @(negedge clk);
    chk("rst_data", {24'd0, data}, 32'd0);
    chk("rst_dv", {31'd0, data_valid}, 32'd0);
    chk("rst_ferr", {31'd0, framing_err}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    drive_bits(1'b1, 2 * c_BIT);

    // Single nominal frame
    send_frame(8'h55, 1'b1, c_BIT);
    drive_bits(1'b1, 2 * c_BIT);
    wait_drain(1000);

    // Back-to-back, no idle gap
    send_frame(8'hA5, 1'b1, c_BIT);
    send_frame(8'h00, 1'b1, c_BIT);
    send_frame(8'hFF, 1'b1, c_BIT);
    drive_bits(1'b1, 2 * c_BIT);
    wait_drain(1000);

    // Start glitch: 40 clk low, then back high
    drive_bits(1'b0, 39);
    chk("glitch_busy_seen", {31'd0, busy}, 32'd1);
    drive_bits(1'b0, 1);
    rxd = 1'b1;
    begin
      int k;
      k = 0;
      while (busy && k < 8 * 28) begin
        @(negedge clk);
        k++;
      end
    end
    chk("glitch_busy_clear", {31'd0, busy}, 32'd0);
    drive_bits(1'b1, 2 * c_BIT);

    // Bad stop bit, line held low for 3 more frames, then released
    send_frame(8'h3C, 1'b0, c_BIT);
    drive_bits(1'b0, 30 * c_BIT);
    chk("break_busy", {31'd0, busy}, 32'd1);
    drive_bits(1'b1, 2 * c_BIT);
    chk("break_data_held", {24'd0, data}, {24'd0, last_good});
    chk("break_released", {31'd0, busy}, 32'd0);
    wait_drain(10);
    send_frame(8'h5A, 1'b1, c_BIT);
    drive_bits(1'b1, 2 * c_BIT);
    wait_drain(1000);

    // Transmitter baud offset of about +3% and -3%
    send_frame(8'hC3, 1'b1, 224);
    drive_bits(1'b1, 2 * c_BIT);
    send_frame(8'hC3, 1'b1, 210);
    drive_bits(1'b1, 2 * c_BIT);
    wait_drain(1000);

    // Reset during bit 4 of 0xF0 (bits 0-3 low, bit 4 high)
    drive_bits(1'b0, c_BIT);
    for (int i = 0; i < 4; i++) drive_bits(1'b0, c_BIT);
    drive_bits(1'b1, 100);
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    chk("midrst_data", {24'd0, data}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    last_good = 8'h00;
    rst_n = 1'b1;
    drive_bits(1'b1, 3 * c_BIT);
    chk("postrst_data", {24'd0, data}, 32'd0);
    send_frame(8'h81, 1'b1, c_BIT);
    drive_bits(1'b1, 2 * c_BIT);
    wait_drain(1000);

    // Randomized frames: byte, stop-bit validity, baud within +/-3%, gap
    for (int n = 0; n < 10; n++) begin
      rb     = 8'($urandom_range(0, 255));
      rs     = ($urandom_range(0, 5) != 0);
      bitclk = $urandom_range(211, 223);
      gap    = $urandom_range(0, 300);
      if ((!rs || bitclk < c_BIT) && gap < 120) gap = 120;
      send_frame(rb, rs, bitclk);
      if (gap > 0) drive_bits(1'b1, gap);
    end
    drive_bits(1'b1, 2 * c_BIT);
    wait_drain(3000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
